go_button_conditioner: RTL and testbench

//   Upstream front end for the LED count FSM. Synchronises and debounces the raw active-low
//   go push-button in the dividedClock domain and issues one go request per accepted press.
//   The request is held until the count FSM acknowledges it via busy.

---
 rtl/go_button_conditioner.sv | 146 ++++++++++++++
 tb/tb_go_button_conditioner.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/go_button_conditioner.sv
// go_button_conditioner: synchronises and debounces the active-low go button in the
// dividedClock domain, raises a go request per accepted press (held until busy acks it)
// and pulses long_press once per long hold.
// Optional feature: define GO_PRESS_COUNT_EN to build the 8-bit accepted-press counter.
module go_button_conditioner #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned DEBOUNCE_TICKS = 2,
    parameter int unsigned LONG_TICKS     = 6,
    parameter int unsigned CNT_W          = 4
) (
    input  logic       dividedClock,
    input  logic       rst,
    input  logic       button_n,
    input  logic       busy,
    output logic       go,
    output logic       pressed,
    output logic       long_press,
    output logic [7:0] press_count
);

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_TICKS - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);
    localparam logic [CNT_W-1:0] LONG_MAX  = CNT_W'(LONG_TICKS);

    typedef enum logic [1:0] {
        RELEASED         = 2'd0,
        PRESS_DEBOUNCE   = 2'd1,
        HELD             = 2'd2,
        RELEASE_DEBOUNCE = 2'd3
    } state_t;

    state_t                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   go_q;
    logic                   pressed_q;
    logic                   long_q;
    logic                   sync_c;
    logic                   accept_c;

    assign sync_c = sync_q[SYNC_STAGES-1];

    // A press is accepted on the debounce-complete edge only if nothing is outstanding and busy is low
    assign accept_c = (state_q == PRESS_DEBOUNCE) && !sync_c && (cnt_q == DEB_LAST)
                      && !busy && !go_q;

    // Input synchroniser chain; resets to the released level
    always_ff @(posedge dividedClock or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], button_n};
        end
    end

    // Debounce FSM with registered go / pressed / long_press
    always_ff @(posedge dividedClock or posedge rst) begin
        if (rst) begin
            state_q   <= RELEASED;
            cnt_q     <= '0;
            go_q      <= 1'b0;
            pressed_q <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            long_q <= 1'b0;
            if (go_q && busy) begin
                go_q <= 1'b0;
            end
            case (state_q)
                RELEASED: begin
                    if (!sync_c) begin
                        state_q <= PRESS_DEBOUNCE;
                        cnt_q   <= '0;
                    end
                end
                PRESS_DEBOUNCE: begin
                    if (sync_c) begin
                        state_q <= RELEASED;
                        cnt_q   <= '0;
                    end else if (cnt_q == DEB_LAST) begin
                        state_q   <= HELD;
                        cnt_q     <= '0;
                        pressed_q <= 1'b1;
                        if (accept_c) begin
                            go_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                HELD: begin
                    if (sync_c) begin
                        state_q <= RELEASE_DEBOUNCE;
                        cnt_q   <= '0;
                    end else if (cnt_q < LONG_MAX) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == LONG_LAST) begin
                            long_q <= 1'b1;
                        end
                    end
                end
                RELEASE_DEBOUNCE: begin
                    if (!sync_c) begin
                        // Return saturated so a bounce back into HELD cannot re-fire long_press
                        state_q <= HELD;
                        cnt_q   <= LONG_MAX;
                    end else if (cnt_q == DEB_LAST) begin
                        state_q   <= RELEASED;
                        cnt_q     <= '0;
                        pressed_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q   <= RELEASED;
                    cnt_q     <= '0;
                    go_q      <= 1'b0;
                    pressed_q <= 1'b0;
                end
            endcase
        end
    end

    assign go         = go_q;
    assign pressed    = pressed_q;
    assign long_press = long_q;

`ifdef GO_PRESS_COUNT_EN
    logic [7:0] press_count_q;

    // Counts accepted presses (each go 0->1), wrapping at 8 bits
    always_ff @(posedge dividedClock or posedge rst) begin
        if (rst) begin
            press_count_q <= 8'h00;
        end else if (accept_c) begin
            press_count_q <= press_count_q + 8'd1;
        end
    end

    assign press_count = press_count_q;
`else
    assign press_count = 8'h00;
`endif

endmodule

// File: tb/tb_go_button_conditioner.sv
// Directed bench for go_button_conditioner: clean press, bounce, busy reject,
// simultaneous busy, long press, no queuing, async reset mid-request, counter wrap.
module tb_go_button_conditioner;

    logic       dividedClock;
    logic       rst;
    logic       button_n;
    logic       busy;
    logic       go;
    logic       pressed;
    logic       long_press;
    logic [7:0] press_count;

    int         n_tests;
    int         n_fail;
    logic [7:0] exp_cnt;

    go_button_conditioner dut (
        .dividedClock (dividedClock),
        .rst          (rst),
        .button_n     (button_n),
        .busy         (busy),
        .go           (go),
        .pressed      (pressed),
        .long_press   (long_press),
        .press_count  (press_count)
    );

    initial dividedClock = 1'b0;
    always #5 dividedClock = ~dividedClock;

    // Expected press_count: model value when the counter is built, else constant zero
    function automatic logic [7:0] cnt_exp();
`ifdef GO_PRESS_COUNT_EN
        return exp_cnt;
`else
        return 8'h00;
`endif
    endfunction

    task automatic tick();
        @(posedge dividedClock);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        exp_cnt  = 8'h00;
        rst      = 1'b1;
        button_n = 1'b1;
        busy     = 1'b0;

        // Reset state
        ticks(2);
        chk("rst go", {7'd0, go}, 8'h00);
        chk("rst pressed", {7'd0, pressed}, 8'h00);
        chk("rst long", {7'd0, long_press}, 8'h00);
        chk("rst cnt", press_count, 8'h00);
        rst = 1'b0;
        tick();

        // 1: clean press, ack at edge 7, release after edge 7
        button_n = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            tick();
            if (e == 5) exp_cnt++;
            chk($sformatf("t1 go e%0d", e), {7'd0, go}, {7'd0, (e >= 5 && e < 7)});
            chk($sformatf("t1 pressed e%0d", e), {7'd0, pressed}, {7'd0, (e >= 5 && e < 12)});
            chk($sformatf("t1 long e%0d", e), {7'd0, long_press}, 8'h00);
            busy = (e == 6);
            if (e == 7) button_n = 1'b1;
        end
        chk("t1 cnt", press_count, cnt_exp());
        ticks(3);

        // 2: one-cycle bounce is rejected
        button_n = 1'b0;
        tick();
        button_n = 1'b1;
        for (int e = 2; e <= 10; e++) begin
            tick();
            chk($sformatf("t2 go e%0d", e), {7'd0, go}, 8'h00);
            chk($sformatf("t2 pressed e%0d", e), {7'd0, pressed}, 8'h00);
        end

        // 3: busy held high discards the press
        busy     = 1'b1;
        button_n = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            chk($sformatf("t3 go e%0d", e), {7'd0, go}, 8'h00);
            chk($sformatf("t3 pressed e%0d", e), {7'd0, pressed}, {7'd0, (e >= 5)});
        end
        button_n = 1'b1;
        ticks(6);
        chk("t3 cnt", press_count, cnt_exp());
        busy = 1'b0;

        // Simultaneous: busy high only on the accept edge
        button_n = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            chk($sformatf("sim go e%0d", e), {7'd0, go}, 8'h00);
            chk($sformatf("sim pressed e%0d", e), {7'd0, pressed}, {7'd0, (e >= 5)});
            busy = (e == 4);
        end
        button_n = 1'b1;
        ticks(6);
        chk("sim cnt", press_count, cnt_exp());

        // 4: long press, one long_press pulse at edge 11
        button_n = 1'b0;
        for (int e = 1; e <= 18; e++) begin
            tick();
            if (e == 5) exp_cnt++;
            chk($sformatf("t4 long e%0d", e), {7'd0, long_press}, {7'd0, (e == 11)});
            chk($sformatf("t4 go e%0d", e), {7'd0, go}, {7'd0, (e == 5 || e == 6)});
            chk($sformatf("t4 pressed e%0d", e), {7'd0, pressed}, {7'd0, (e >= 5 && e < 17)});
            busy = (e == 6);
            if (e == 12) button_n = 1'b1;
        end
        chk("t4 cnt", press_count, cnt_exp());
        ticks(3);

        // 7: short press keeps go; second press while go=1 is not queued
        button_n = 1'b0;
        ticks(5);
        exp_cnt++;
        chk("t7 go first", {7'd0, go}, 8'h01);
        button_n = 1'b1;
        ticks(8);
        chk("t7 go after release", {7'd0, go}, 8'h01);
        chk("t7 pressed released", {7'd0, pressed}, 8'h00);
        button_n = 1'b0;
        ticks(6);
        chk("t7 pressed second", {7'd0, pressed}, 8'h01);
        chk("t7 cnt second", press_count, cnt_exp());
        busy = 1'b1;
        tick();
        chk("t7 go ack", {7'd0, go}, 8'h00);
        busy = 1'b0;
        ticks(3);
        chk("t7 go not queued", {7'd0, go}, 8'h00);
        button_n = 1'b1;
        ticks(8);

        // 5: asynchronous reset mid-request, button still held
        button_n = 1'b0;
        ticks(5);
        exp_cnt++;
        chk("t5 go before rst", {7'd0, go}, 8'h01);
        #2;
        rst = 1'b1;
        exp_cnt = 8'h00;
        #1;
        chk("t5 go async", {7'd0, go}, 8'h00);
        chk("t5 pressed async", {7'd0, pressed}, 8'h00);
        chk("t5 cnt async", press_count, 8'h00);
        tick();
        rst = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            tick();
            if (e == 5) exp_cnt++;
            chk($sformatf("t5 go e%0d", e), {7'd0, go}, {7'd0, (e >= 5)});
            chk($sformatf("t5 pressed e%0d", e), {7'd0, pressed}, {7'd0, (e >= 5)});
        end
        chk("t5 cnt", press_count, cnt_exp());
        busy = 1'b1;
        tick();
        busy = 1'b0;
        chk("t5 go ack", {7'd0, go}, 8'h00);
        button_n = 1'b1;
        ticks(8);

        // 6: 256 accepted presses from reset wrap the counter back to zero
        rst = 1'b1;
        tick();
        rst     = 1'b0;
        exp_cnt = 8'h00;
        tick();
        for (int p = 0; p < 256; p++) begin
            button_n = 1'b0;
            ticks(5);
            exp_cnt++;
            busy = 1'b1;
            tick();
            busy     = 1'b0;
            button_n = 1'b1;
            ticks(7);
            if (p == 127) chk("t6 cnt half", press_count, cnt_exp());
        end
        chk("t6 cnt wrap", press_count, cnt_exp());
        chk("t6 cnt zero", press_count, 8'h00);
        chk("t6 go idle", {7'd0, go}, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
